universal_shift_register: RTL and testbench
===========================================

// Module: universal_shift_register
// PURPOSE
//  Parametrised universal shift register with N-bit parallel load, logical and arithmetic shifts,
//  and a counted burst-shift sequencer (busy/done handshake).
//  Serial-transfer building block for the Module 5 register datapaths.
//  Single clock domain; every state change happens on posedge clk.
// PARAMETERS
//  N   8  register width in bits (N >= 2)
//  CW  localparam = $clog2(N+1); width of the burst-count input
// PORTS
//  clk      in   1    system clock, rising edge
//  reset_n  in   1    reset; synchronous, active-low
//  en       in   1    apply mode this cycle (IDLE only)
//  mode     in   3    single-cycle operation select (see BEHAVIOUR)
//  SI_R     in   1    serial in for right shifts; enters Q[N-1]
//  SI_L     in   1    serial in for left shifts; enters Q[0]
//  I        in   N    parallel load data
//  start    in   1    begin a burst shift (IDLE only)
//  amt      in   CW   burst shift count
//  dir      in   1    burst direction: 0 = right, 1 = left
//  Q        out  N    register contents
//  SO_R     out  1    Q[0]; right-shift serial out
//  SO_L     out  1    Q[N-1]; left-shift serial out
//  busy     out  1    burst in progress
//  done     out  1    one-cycle pulse when a burst completes
// BEHAVIOUR
//  - Reset: reset_n low at a clk edge -> Q=0, FSM=IDLE, busy=0, done=0. Reset overrides start, en
//    and any burst in progress. An aborted burst never asserts done.
//  - Mode codes, IDLE with en=1 and start=0. Result appears in Q after the next edge.
//      000 hold
//      001 SRL: Q <= {SI_R, Q[N-1:1]}
//      010 SLL: Q <= {Q[N-2:0], SI_L}
//      011 load: Q <= I
//      100 ASR: Q <= {Q[N-1], Q[N-1:1]}
//      101 ROR, 110 ROL: see CONFIGURATION
//      111 reserved: hold
//  - en=0 in IDLE: Q holds.
//  - FSM states: IDLE and SHIFT.
//  - IDLE -> SHIFT: start=1 and amt!=0 at an edge. That edge captures cnt=min(amt,N) and dir.
//    Q is unchanged at that edge; busy=1 after it.
//  - start with amt=0: ignored. No state change, no done pulse.
//  - start and en both high in IDLE: start wins and the mode op is discarded.
//  - SHIFT: each edge performs one SRL (dir=0) or SLL (dir=1) using SI_R/SI_L sampled at that edge,
//    then decrements cnt. The edge that performs the last shift returns the FSM to IDLE.
//    After that edge busy=0 and done=1 for exactly one cycle.
//  - Latency: start at edge 0 -> shifts at edges 1..cnt -> done high after edge cnt.
//  - While busy: start, en, mode, amt and dir are ignored. dir is latched for the whole burst.
//  - A new start may be sampled in the same cycle done is high; it begins the next burst.
//  - done is never high while busy is high.
//  - SO_R and SO_L are combinational taps of Q. No extra latency.
// CONFIGURATION
//  USR_ROTATE_EN defined:
//   - 101 ROR: Q <= {Q[0], Q[N-1:1]}
//   - 110 ROL: Q <= {Q[N-2:0], Q[N-1]}
//  USR_ROTATE_EN undefined:
//   - codes 101 and 110 behave as hold. No rotate logic is synthesised.
//  Burst shifting is identical in both builds.
// TESTING (N=8)
//  1. Q=0xA5, reset_n=0 for 1 edge -> Q=0x00, busy=0, done=0. Repeat mid-burst with the same result.
//  2. load I=0xB4; SRL SI_R=1 -> Q=0xDA; SLL SI_L=0 -> Q=0xB4; en=0 for 3 edges -> Q stays 0xB4.
//  3. load 0x80, ASR x3 -> Q=0xF0; mode=111 -> Q stays 0xF0.
//  4. Q=0x01, start amt=3 dir=1 SI_L=0 -> busy=1 for 3 cycles, Q=0x08, done 1-cycle pulse;
//     toggling en/mode/start during the burst has no effect.
//  5. Q=0x00, start amt=12 dir=0 SI_R=1 -> clamps to 8 shifts, Q=0xFF, done after edge 8;
//     start amt=0 -> busy and done stay 0.
//  6. Q=0x81, mode=101 -> 0xC0 with USR_ROTATE_EN, 0x81 without;
//     mode=110 from 0x81 -> 0x03 with the macro, 0x81 without.

Source files
------------

// File: rtl/universal_shift_register.sv
// Universal N-bit shift register: load, SRL/SLL/ASR ops plus a counted burst shifter (busy/done).
// Mode ops land in Q one edge after they are sampled; a burst of cnt shifts raises done after edge cnt.
// No backpressure: start/en are sampled in IDLE only and ignored while busy. USR_ROTATE_EN adds ROR/ROL.
module universal_shift_register #(
  parameter int N = 8,
  localparam int CW = $clog2(N+1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  input  logic [2:0]    mode,
  input  logic          SI_R,
  input  logic          SI_L,
  input  logic [N-1:0]  I,
  input  logic          start,
  input  logic [CW-1:0] amt,
  input  logic          dir,
  output logic [N-1:0]  Q,
  output logic          SO_R,
  output logic          SO_L,
  output logic          busy,
  output logic          done
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [CW-1:0] N_CNT   = CW'(N);
  localparam logic [CW-1:0] ONE_CNT = CW'(1);

  state_t        state, state_nxt;
  logic [N-1:0]  q_r, q_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          dir_r, dir_nxt;
  logic          done_r, done_nxt;
  logic [N-1:0]  srl_val, sll_val, mode_val;

  assign srl_val = {SI_R, q_r[N-1:1]};
  assign sll_val = {q_r[N-2:0], SI_L};

  always_comb begin
    mode_val = q_r;
    case (mode)
      3'b001:  mode_val = srl_val;
      3'b010:  mode_val = sll_val;
      3'b011:  mode_val = I;
      3'b100:  mode_val = {q_r[N-1], q_r[N-1:1]};
`ifdef USR_ROTATE_EN
      3'b101:  mode_val = {q_r[0], q_r[N-1:1]};
      3'b110:  mode_val = {q_r[N-2:0], q_r[N-1]};
`endif
      default: mode_val = q_r;
    endcase
  end

  always_comb begin
    state_nxt = state;
    q_nxt     = q_r;
    cnt_nxt   = cnt;
    dir_nxt   = dir_r;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        // A start of any amount suppresses the mode op; amt=0 simply does nothing.
        if (start) begin
          if (amt != '0) begin
            state_nxt = SHIFT;
            cnt_nxt   = (amt > N_CNT) ? N_CNT : amt;
            dir_nxt   = dir;
          end
        end else if (en) begin
          q_nxt = mode_val;
        end
      end
      SHIFT: begin
        q_nxt   = dir_r ? sll_val : srl_val;
        cnt_nxt = cnt - ONE_CNT;
        if (cnt == ONE_CNT) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      q_r    <= '0;
      cnt    <= '0;
      dir_r  <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      q_r    <= q_nxt;
      cnt    <= cnt_nxt;
      dir_r  <= dir_nxt;
      done_r <= done_nxt;
    end
  end

  assign Q    = q_r;
  assign SO_R = q_r[0];
  assign SO_L = q_r[N-1];
  assign busy = (state == SHIFT);
  assign done = done_r;

endmodule

// File: tb/tb_universal_shift_register.sv
// Table-driven bench for universal_shift_register (N=8); expected results go through a scoreboard queue.
module tb_universal_shift_register;

  localparam int N  = 8;
  localparam int CW = $clog2(N+1);

`ifdef USR_ROTATE_EN
  localparam logic [7:0] ROR_81 = 8'hC0;
  localparam logic [7:0] ROL_81 = 8'h03;
`else
  localparam logic [7:0] ROR_81 = 8'h81;
  localparam logic [7:0] ROL_81 = 8'h81;
`endif

  logic          clk = 1'b0;
  logic          reset_n, en, SI_R, SI_L, start, dir;
  logic [2:0]    mode;
  logic [N-1:0]  I;
  logic [CW-1:0] amt;
  logic [N-1:0]  Q;
  logic          SO_R, SO_L, busy, done;

  universal_shift_register #(.N(N)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .SI_R(SI_R), .SI_L(SI_L),
    .I(I), .start(start), .amt(amt), .dir(dir),
    .Q(Q), .SO_R(SO_R), .SO_L(SO_L), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst_n;
    logic          en;
    logic [2:0]    mode;
    logic          si_r;
    logic          si_l;
    logic [7:0]    i;
    logic          start;
    logic [CW-1:0] amt;
    logic          dir;
    logic [7:0]    q;
    logic          busy;
    logic          done;
    string         name;
  } vec_t;

  typedef struct {
    logic [7:0] q;
    logic       busy;
    logic       done;
    string      name;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(logic r, logic e, logic [2:0] m, logic sr, logic sl, logic [7:0] d,
                              logic st, logic [CW-1:0] a, logic dr,
                              logic [7:0] q, logic b, logic dn, string nm);
    vec_t v;
    v.rst_n = r; v.en = e; v.mode = m; v.si_r = sr; v.si_l = sl; v.i = d;
    v.start = st; v.amt = a; v.dir = dr; v.q = q; v.busy = b; v.done = dn; v.name = nm;
    return v;
  endfunction

  task automatic check_pop();
    exp_t e;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: no expected entry for DUT output");
      return;
    end
    e = sb.pop_front();
    n_vec++;
    if ({Q, busy, done, SO_R, SO_L} !== {e.q, e.busy, e.done, e.q[0], e.q[7]}) begin
      n_fail++;
      $display("FAIL %s: got Q=%h busy=%b done=%b SO_R=%b SO_L=%b, want Q=%h busy=%b done=%b SO_R=%b SO_L=%b",
               e.name, Q, busy, done, SO_R, SO_L, e.q, e.busy, e.done, e.q[0], e.q[7]);
    end
  endtask

  task automatic apply(vec_t v);
    exp_t e;
    reset_n = v.rst_n; en = v.en; mode = v.mode; SI_R = v.si_r; SI_L = v.si_l;
    I = v.i; start = v.start; amt = v.amt; dir = v.dir;
    e.q = v.q; e.busy = v.busy; e.done = v.done; e.name = v.name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_pop();
  endtask

  // Helpers for hand-written sequences: an idle/ignored-input cycle and a burst start.
  task automatic step(logic e, logic [2:0] m, logic sr, logic sl, logic [7:0] d, logic st,
                      logic [CW-1:0] a, logic dr, logic [7:0] q, logic b, logic dn, string nm);
    apply(mk(1'b1, e, m, sr, sl, d, st, a, dr, q, b, dn, nm));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; en = 1'b0; mode = 3'b000; SI_R = 1'b0; SI_L = 1'b0;
    I = '0; start = 1'b0; amt = '0; dir = 1'b0;
    #2;

    //             rst en mode   sr  sl  I      st  amt dir  Q       busy done
    tbl.push_back(mk(0, 0, 3'b000, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, "reset_initial"));
    tbl.push_back(mk(1, 1, 3'b011, 0, 0, 8'hA5, 0, 0, 0, 8'hA5, 0, 0, "load_A5"));
    tbl.push_back(mk(0, 1, 3'b011, 0, 0, 8'hFF, 1, 3, 0, 8'h00, 0, 0, "reset_over_load_start"));
    tbl.push_back(mk(1, 1, 3'b011, 0, 0, 8'hB4, 0, 0, 0, 8'hB4, 0, 0, "load_B4"));
    tbl.push_back(mk(1, 1, 3'b001, 1, 0, 8'h00, 0, 0, 0, 8'hDA, 0, 0, "srl_si1"));
    tbl.push_back(mk(1, 1, 3'b010, 1, 0, 8'h00, 0, 0, 0, 8'hB4, 0, 0, "sll_si0"));
    tbl.push_back(mk(1, 0, 3'b001, 1, 1, 8'h00, 0, 0, 0, 8'hB4, 0, 0, "en0_hold_1"));
    tbl.push_back(mk(1, 0, 3'b011, 1, 1, 8'h11, 0, 0, 0, 8'hB4, 0, 0, "en0_hold_2"));
    tbl.push_back(mk(1, 0, 3'b010, 1, 1, 8'h22, 0, 0, 0, 8'hB4, 0, 0, "en0_hold_3"));
    tbl.push_back(mk(1, 1, 3'b011, 0, 0, 8'h80, 0, 0, 0, 8'h80, 0, 0, "load_80"));
    tbl.push_back(mk(1, 1, 3'b100, 0, 0, 8'h00, 0, 0, 0, 8'hC0, 0, 0, "asr_1"));
    tbl.push_back(mk(1, 1, 3'b100, 0, 0, 8'h00, 0, 0, 0, 8'hE0, 0, 0, "asr_2"));
    tbl.push_back(mk(1, 1, 3'b100, 1, 1, 8'h00, 0, 0, 0, 8'hF0, 0, 0, "asr_3"));
    tbl.push_back(mk(1, 1, 3'b111, 0, 1, 8'h00, 0, 0, 0, 8'hF0, 0, 0, "mode111_hold"));
    tbl.push_back(mk(1, 1, 3'b000, 1, 1, 8'h00, 0, 0, 0, 8'hF0, 0, 0, "mode000_hold"));
    tbl.push_back(mk(1, 1, 3'b011, 0, 0, 8'h81, 0, 0, 0, 8'h81, 0, 0, "load_81a"));
    tbl.push_back(mk(1, 1, 3'b101, 0, 0, 8'h00, 0, 0, 0, ROR_81, 0, 0, "mode101_ror"));
    tbl.push_back(mk(1, 1, 3'b011, 0, 0, 8'h81, 0, 0, 0, 8'h81, 0, 0, "load_81b"));
    tbl.push_back(mk(1, 1, 3'b110, 0, 0, 8'h00, 0, 0, 0, ROL_81, 0, 0, "mode110_rol"));
    tbl.push_back(mk(1, 1, 3'b011, 0, 0, 8'h3C, 0, 0, 0, 8'h3C, 0, 0, "load_3C"));
    tbl.push_back(mk(1, 0, 3'b000, 1, 1, 8'h00, 1, 0, 1, 8'h3C, 0, 0, "start_amt0_ignored"));

    for (int k = 0; k < tbl.size(); k++) apply(tbl[k]);

    // Burst left by 3 from 0x01; en/mode/start toggled while busy must not matter.
    step(1, 3'b011, 0, 0, 8'h01, 0, 0, 0, 8'h01, 0, 0, "b4_load_01");
    step(0, 3'b000, 0, 0, 8'h00, 1, 3, 1, 8'h01, 1, 0, "b4_start");
    step(1, 3'b011, 1, 0, 8'hFF, 1, 1, 0, 8'h02, 1, 0, "b4_shift1");
    step(0, 3'b001, 1, 0, 8'hFF, 0, 7, 0, 8'h04, 1, 0, "b4_shift2");
    step(1, 3'b100, 1, 0, 8'hFF, 1, 2, 0, 8'h08, 0, 1, "b4_done");
    step(0, 3'b000, 0, 0, 8'h00, 0, 0, 0, 8'h08, 0, 0, "b4_done_clears");

    // Burst right, amt=12 clamps to 8 shifts of SI_R=1 into 0x00.
    apply(mk(0, 0, 3'b000, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, "b5_reset"));
    step(0, 3'b000, 1, 0, 8'h00, 1, 12, 0, 8'h00, 1, 0, "b5_start");
    for (int k = 1; k <= 8; k++) begin
      logic [7:0] ev;
      ev = 8'hFF << (8 - k);
      step(1, 3'b011, 1, 0, 8'h00, 1, 1, 1, ev, (k < 8), (k == 8), $sformatf("b5_shift%0d", k));
    end
    step(0, 3'b000, 0, 0, 8'h00, 1, 0, 0, 8'hFF, 0, 0, "b5_amt0_ignored");
    step(0, 3'b000, 0, 0, 8'h00, 0, 0, 0, 8'hFF, 0, 0, "b5_idle");

    // Restart sampled in the same cycle done is high.
    step(1, 3'b000, 0, 0, 8'h00, 1, 1, 1, 8'hFF, 1, 0, "rs_start1");
    step(0, 3'b000, 0, 0, 8'h00, 0, 0, 0, 8'hFE, 0, 1, "rs_done1");
    step(0, 3'b000, 0, 0, 8'h00, 1, 2, 0, 8'hFE, 1, 0, "rs_start_on_done");
    step(0, 3'b000, 0, 1, 8'h00, 0, 0, 1, 8'h7F, 1, 0, "rs_shift1");
    step(0, 3'b000, 0, 1, 8'h00, 0, 0, 1, 8'h3F, 0, 1, "rs_done2");

    // Reset mid-burst aborts and never produces done.
    step(1, 3'b011, 0, 0, 8'hA5, 0, 0, 0, 8'hA5, 0, 0, "rm_load_A5");
    step(0, 3'b000, 0, 0, 8'h00, 1, 5, 0, 8'hA5, 1, 0, "rm_start");
    step(0, 3'b000, 0, 0, 8'h00, 0, 0, 0, 8'h52, 1, 0, "rm_shift1");
    apply(mk(0, 1, 3'b011, 1, 1, 8'hFF, 1, 3, 0, 8'h00, 0, 0, "rm_reset"));
    for (int k = 0; k < 5; k++)
      step(0, 3'b000, 1, 1, 8'h00, 0, 0, 0, 8'h00, 0, 0, $sformatf("rm_no_done%0d", k));

    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d pending entries, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
